// File: rtl/timer_ctrl.sv
// timer_ctrl: CSR-programmable system timer.
// A prescaler divides clk_i into ticks; each tick advances COUNT, which is
// compared against COMPARE to raise a sticky MATCH flag and a level interrupt.
module timer_ctrl #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] PRESCALE_RST = 32'd9999
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  tick_o,
    output logic [31:0]           count_o,
    output logic                  irq_o
);

    // Register select codes taken from addr_i[4:2]
    localparam logic [2:0] SEL_CTRL     = 3'd0;
    localparam logic [2:0] SEL_PRESCALE = 3'd1;
    localparam logic [2:0] SEL_COMPARE  = 3'd2;
    localparam logic [2:0] SEL_COUNT    = 3'd3;
    localparam logic [2:0] SEL_STATUS   = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;

    logic [2:0]            ctrl_q,     ctrl_d;
    logic [31:0]           prescale_q, prescale_d;
    logic [31:0]           compare_q,  compare_d;
    logic [31:0]           count_q,    count_d;
    logic                  match_q,    match_d;
    logic [31:0]           pre_q,      pre_d;
    logic                  ack_q,      ack_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic                  tick_q,     tick_d;

    logic [2:0]  sel;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic        tick_now;
    logic        count_wr;
    logic [31:0] count_next;
    logic        count_hit;
    logic [31:0] read_val;

    // Address bits outside [4:2] belong to the external base decode
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[ADDR_WIDTH-1:5], addr_i[1:0]};

    assign sel   = addr_i[4:2];
    assign wdata = wdata_i[31:0];
    assign wr_en = req_i & we_i;
    assign rd_en = req_i & ~we_i;

    // Prescaler and counter advance; a COUNT write overrides any tick this cycle
    always_comb begin
        tick_now   = ctrl_q[CTRL_EN] && (pre_q >= prescale_q);
        count_wr   = wr_en && (sel == SEL_COUNT);
        count_next = count_q + 32'd1;
        count_hit  = (count_next == compare_q);

        pre_d = pre_q;
        if (!ctrl_q[CTRL_EN] || count_wr || tick_now) begin
            pre_d = 32'd0;
        end else begin
            pre_d = pre_q + 32'd1;
        end

        count_d = count_q;
        if (count_wr) begin
            count_d = wdata;
        end else if (tick_now) begin
            if (count_hit && ctrl_q[CTRL_AUTO_RELOAD]) begin
                count_d = 32'd0;
            end else begin
                count_d = count_next;
            end
        end

        tick_d = tick_now;
    end

    // CSR writes; a MATCH set from a tick takes priority over a same-cycle clear
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        match_d    = match_q;

        if (wr_en) begin
            case (sel)
                SEL_CTRL:     ctrl_d     = wdata[2:0];
                SEL_PRESCALE: prescale_d = wdata;
                SEL_COMPARE:  compare_d  = wdata;
                SEL_STATUS:   if (wdata[0]) match_d = 1'b0;
                default:      ;
            endcase
        end

        if (tick_now && !count_wr && count_hit) begin
            match_d = 1'b1;
        end
    end

    // Read mux returns pre-edge register values; rdata is zero unless acknowledging a read
    always_comb begin
        read_val = 32'd0;
        case (sel)
            SEL_CTRL:     read_val = {29'd0, ctrl_q};
            SEL_PRESCALE: read_val = prescale_q;
            SEL_COMPARE:  read_val = compare_q;
            SEL_COUNT:    read_val = count_q;
            SEL_STATUS:   read_val = {31'd0, match_q};
            default:      read_val = 32'd0;
        endcase

        rdata_d = '0;
        if (rd_en) begin
            rdata_d = DATA_WIDTH'(read_val);
        end

        ack_d = req_i;
    end

    // State registers, all cleared asynchronously while rst_i is low
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q     <= 3'd0;
            prescale_q <= PRESCALE_RST;
            compare_q  <= 32'hFFFF_FFFF;
            count_q    <= 32'd0;
            match_q    <= 1'b0;
            pre_q      <= 32'd0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            tick_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            match_q    <= match_d;
            pre_q      <= pre_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            tick_q     <= tick_d;
        end
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign tick_o  = tick_q;
    assign count_o = count_q;
    assign irq_o   = match_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl.
// Inputs change and outputs are sampled 1ns after each rising clock edge.
module tb_timer_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        tick_o;
    logic [31:0] count_o;
    logic        irq_o;

    int total;
    int bad;

    logic [31:0] rd;

    timer_ctrl #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .PRESCALE_RST(32'd9999)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .ack_o  (ack_o),
        .rdata_o(rdata_o),
        .tick_o (tick_o),
        .count_o(count_o),
        .irq_o  (irq_o)
    );

    // 10ns clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Count a comparison and report it when the observed value is wrong
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle 1ns past the edge
    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    // One bus access: driven now, sampled at the next edge, acked in the following cycle
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        stepCycle();
        checkOutput("ack", {31'd0, ack_o}, 32'd1);
        rdata   = rdata_o;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = 32'd0;
        wdata_i = 32'd0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_i   = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = 32'd0;
        wdata_i = 32'd0;

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        stepCycle();

        // Run the timer until an interrupt is pending, then reset mid-run
        applyStimulus(1'b1, 32'h04, 32'd0, rd);
        applyStimulus(1'b1, 32'h08, 32'd2, rd);
        applyStimulus(1'b1, 32'h00, 32'd7, rd);
        repeat (3) stepCycle();
        checkOutput("pre_reset_irq", {31'd0, irq_o}, 32'd1);
        rst_i = 1'b0;
        #2;
        checkOutput("rst_count", count_o, 32'd0);
        checkOutput("rst_irq", {31'd0, irq_o}, 32'd0);
        checkOutput("rst_ack", {31'd0, ack_o}, 32'd0);
        checkOutput("rst_tick", {31'd0, tick_o}, 32'd0);
        checkOutput("rst_rdata", rdata_o, 32'd0);
        stepCycle();
        rst_i = 1'b1;
        stepCycle();

        // Reset defaults
        applyStimulus(1'b0, 32'h00, 32'd0, rd);
        checkOutput("def_ctrl", rd, 32'd0);
        stepCycle();
        checkOutput("ack_idle", {31'd0, ack_o}, 32'd0);
        applyStimulus(1'b0, 32'h04, 32'd0, rd);
        checkOutput("def_prescale", rd, 32'd9999);
        applyStimulus(1'b0, 32'h08, 32'd0, rd);
        checkOutput("def_compare", rd, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 32'h0C, 32'd0, rd);
        checkOutput("def_count", rd, 32'd0);
        applyStimulus(1'b0, 32'h10, 32'd0, rd);
        checkOutput("def_status", rd, 32'd0);

        // Tick rate: PRESCALE=3 gives a tick on every 4th edge after enable
        applyStimulus(1'b1, 32'h04, 32'd3, rd);
        applyStimulus(1'b1, 32'h00, 32'd1, rd);
        for (int i = 1; i <= 20; i++) begin
            stepCycle();
            checkOutput($sformatf("tick_%0d", i), {31'd0, tick_o}, (i % 4 == 0) ? 32'd1 : 32'd0);
        end
        checkOutput("tick_count_o", count_o, 32'd5);
        applyStimulus(1'b0, 32'h0C, 32'd0, rd);
        checkOutput("tick_count_rd", rd, 32'd5);
        applyStimulus(1'b1, 32'h00, 32'd0, rd);

        // Compare with auto-reload: COUNT runs 1,2,0,1,2,0
        applyStimulus(1'b1, 32'h04, 32'd0, rd);
        applyStimulus(1'b1, 32'h08, 32'd3, rd);
        applyStimulus(1'b1, 32'h0C, 32'd0, rd);
        applyStimulus(1'b1, 32'h00, 32'd7, rd);
        for (int i = 1; i <= 6; i++) begin
            stepCycle();
            checkOutput($sformatf("ar_count_%0d", i), count_o, (i % 3 == 0) ? 32'd0 : 32'(i % 3));
            checkOutput($sformatf("ar_irq_%0d", i), {31'd0, irq_o}, (i >= 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b1, 32'h10, 32'd1, rd);
        checkOutput("w1c_irq", {31'd0, irq_o}, 32'd0);
        stepCycle();
        applyStimulus(1'b1, 32'h10, 32'd1, rd);
        checkOutput("w1c_collide_count", count_o, 32'd0);
        checkOutput("w1c_collide_irq", {31'd0, irq_o}, 32'd1);
        applyStimulus(1'b1, 32'h00, 32'd0, rd);
        applyStimulus(1'b1, 32'h10, 32'd0, rd);
        applyStimulus(1'b0, 32'h10, 32'd0, rd);
        checkOutput("w0_keeps_match", rd, 32'd1);
        applyStimulus(1'b1, 32'h10, 32'd1, rd);
        applyStimulus(1'b0, 32'h10, 32'd0, rd);
        checkOutput("status_cleared", rd, 32'd0);

        // Wrap and one-shot: 0xFFFFFFFE -> 0xFFFFFFFF -> 0 (match) -> 1
        applyStimulus(1'b1, 32'h0C, 32'hFFFF_FFFE, rd);
        applyStimulus(1'b1, 32'h08, 32'd0, rd);
        applyStimulus(1'b1, 32'h00, 32'd5, rd);
        stepCycle();
        checkOutput("wrap_count_1", count_o, 32'hFFFF_FFFF);
        checkOutput("wrap_irq_1", {31'd0, irq_o}, 32'd0);
        stepCycle();
        checkOutput("wrap_count_2", count_o, 32'd0);
        checkOutput("wrap_irq_2", {31'd0, irq_o}, 32'd1);
        stepCycle();
        checkOutput("wrap_count_3", count_o, 32'd1);
        applyStimulus(1'b1, 32'h00, 32'd0, rd);
        applyStimulus(1'b1, 32'h10, 32'd1, rd);

        // COUNT write on a tick cycle wins over the increment
        applyStimulus(1'b1, 32'h08, 32'hFFFF_FFFF, rd);
        applyStimulus(1'b1, 32'h00, 32'd1, rd);
        applyStimulus(1'b1, 32'h0C, 32'd100, rd);
        checkOutput("collide_count_o", count_o, 32'd100);
        applyStimulus(1'b0, 32'h0C, 32'd0, rd);
        checkOutput("collide_count_rd", rd, 32'd100);
        applyStimulus(1'b1, 32'h00, 32'd0, rd);
        checkOutput("stopped_count", count_o, 32'd102);

        // Back-to-back burst of mixed accesses
        applyStimulus(1'b1, 32'h08, 32'h0000_1234, rd);
        applyStimulus(1'b0, 32'h08, 32'd0, rd);
        checkOutput("burst_compare", rd, 32'h0000_1234);
        applyStimulus(1'b1, 32'h04, 32'h0000_0055, rd);
        applyStimulus(1'b0, 32'h04, 32'd0, rd);
        checkOutput("burst_prescale", rd, 32'h0000_0055);
        stepCycle();
        checkOutput("burst_end_ack", {31'd0, ack_o}, 32'd0);
        checkOutput("burst_end_rdata", rdata_o, 32'd0);

        // Unmapped offsets and CTRL reserved bits
        applyStimulus(1'b0, 32'h18, 32'd0, rd);
        checkOutput("rd_0x18", rd, 32'd0);
        applyStimulus(1'b1, 32'h18, 32'hFFFF_FFFF, rd);
        applyStimulus(1'b1, 32'h00, 32'hFFFF_FFF8, rd);
        applyStimulus(1'b0, 32'h00, 32'd0, rd);
        checkOutput("post_ctrl", rd, 32'd0);
        applyStimulus(1'b0, 32'h04, 32'd0, rd);
        checkOutput("post_prescale", rd, 32'h0000_0055);
        applyStimulus(1'b0, 32'h08, 32'd0, rd);
        checkOutput("post_compare", rd, 32'h0000_1234);
        applyStimulus(1'b0, 32'h0C, 32'd0, rd);
        checkOutput("post_count", rd, 32'd102);
        applyStimulus(1'b0, 32'h10, 32'd0, rd);
        checkOutput("post_status", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
